// File: rtl/jk_excitation_driver_if.sv
// Bus between a target source, the JK excitation driver and the JK register bank it commands.
// The slave modport is the driver's view; master is the view of the source plus bank.
interface jk_excitation_driver_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     tgt_data;
  logic                 tgt_valid;
  logic                 tgt_ready;
  logic [WIDTH-1:0]     j;
  logic [WIDTH-1:0]     k;
  logic [WIDTH-1:0]     q_fb;
  logic                 busy;
  logic                 done;
  logic                 mismatch;
  logic [WIDTH-1:0]     mismatch_bits;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport slave (
    input  tgt_data, tgt_valid, q_fb,
    output tgt_ready, j, k, busy, done, mismatch, mismatch_bits, err_cnt
  );

  modport master (
    output tgt_data, tgt_valid, q_fb,
    input  tgt_ready, j, k, busy, done, mismatch, mismatch_bits, err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Turns a requested next state into one cycle of J/K commands for an external JK bank,
// then reads the bank back and reports/counts any bits that missed the target.
module jk_excitation_driver #(
  parameter int WIDTH     = 8,
  parameter int XFILL     = 0,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  jk_excitation_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic                 ready;
  logic                 accept;
  logic                 check_now;
  logic [WIDTH-1:0]     j_calc, k_calc;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     tgt_reg;
  logic [WIDTH-1:0]     j_reg, k_reg;
  logic                 done_reg;
  logic                 mismatch_reg;
  logic [WIDTH-1:0]     mismatch_bits_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  // Per-bit excitation from current Q (c) and requested Q (t).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_exc
    if (XFILL == 0) begin : g_hold_fill
      assign j_calc[gi] = ~bus.q_fb[gi] & bus.tgt_data[gi];
      assign k_calc[gi] = bus.q_fb[gi] & ~bus.tgt_data[gi];
    end else begin : g_toggle_fill
      assign j_calc[gi] = bus.q_fb[gi] | bus.tgt_data[gi];
      assign k_calc[gi] = ~(bus.q_fb[gi] & bus.tgt_data[gi]);
    end
  end

  assign ready = (state_reg == IDLE) & ~rst;
  assign diff  = tgt_reg ^ bus.q_fb;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    check_now  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.tgt_valid && ready) begin
          accept     = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: state_next = CHECK;
      CHECK: begin
        check_now  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      tgt_reg           <= '0;
      j_reg             <= '0;
      k_reg             <= '0;
      done_reg          <= 1'b0;
      mismatch_reg      <= 1'b0;
      mismatch_bits_reg <= '0;
      err_cnt_reg       <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= check_now;
      // Commands exist only for the DRIVE cycle; everywhere else the bank holds.
      if (accept) begin
        tgt_reg <= bus.tgt_data;
        j_reg   <= j_calc;
        k_reg   <= k_calc;
      end else begin
        j_reg <= '0;
        k_reg <= '0;
      end
      if (check_now) begin
        mismatch_bits_reg <= diff;
        mismatch_reg      <= |diff;
        if ((|diff) && (err_cnt_reg != {ERR_CNT_W{1'b1}})) begin
          err_cnt_reg <= err_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign bus.tgt_ready     = ready;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.j             = j_reg;
  assign bus.k             = k_reg;
  assign bus.done          = done_reg;
  assign bus.mismatch      = mismatch_reg;
  assign bus.mismatch_bits = mismatch_bits_reg;
  assign bus.err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: three drivers (XFILL=0, XFILL=1, XFILL=0 with a 2-bit error counter), each with a JK bank model
// that can have bits stuck at 0; transfers are checked against an excitation-table reference.
module tb_jk_excitation_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][7:0] tgt_data_a;
  logic [2:0]      tgt_valid_a;
  logic [2:0][7:0] stuck_a;
  logic [2:0][7:0] bank_q;
  logic [2:0][7:0] j_o, k_o, mmb_o, errc_o;
  logic [2:0]      ready_o, busy_o, done_o, mm_o;

  int total = 0;
  int bad   = 0;
  int err_model [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int XF = (gi == 1) ? 1 : 0;
    localparam int EW = (gi == 2) ? 2 : 8;

    jk_excitation_driver_if #(.WIDTH(8), .ERR_CNT_W(EW)) ifc ();

    jk_excitation_driver #(.WIDTH(8), .XFILL(XF), .ERR_CNT_W(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );

    assign ifc.tgt_data  = tgt_data_a[gi];
    assign ifc.tgt_valid = tgt_valid_a[gi];
    assign ifc.q_fb      = bank_q[gi];
    assign j_o[gi]       = ifc.j;
    assign k_o[gi]       = ifc.k;
    assign ready_o[gi]   = ifc.tgt_ready;
    assign busy_o[gi]    = ifc.busy;
    assign done_o[gi]    = ifc.done;
    assign mm_o[gi]      = ifc.mismatch;
    assign mmb_o[gi]     = ifc.mismatch_bits;
    assign errc_o[gi]    = 8'(ifc.err_cnt);

    // External JK bank: Q+ = J~Q | ~KQ, with optional stuck-at-0 bits.
    always_ff @(posedge clk) begin
      if (rst) bank_q[gi] <= 8'h00;
      else     bank_q[gi] <= ((ifc.j & ~bank_q[gi]) | (~ifc.k & bank_q[gi])) & ~stuck_a[gi];
    end
  end

  // Excitation table lookup, bit by bit.
  function automatic void exc(input bit xf, input logic [7:0] c, input logic [7:0] t,
                              output logic [7:0] ej, output logic [7:0] ek);
    for (int b = 0; b < 8; b++) begin
      case ({c[b], t[b]})
        2'b00: {ej[b], ek[b]} = xf ? 2'b01 : 2'b00;
        2'b01: {ej[b], ek[b]} = xf ? 2'b11 : 2'b10;
        2'b10: {ej[b], ek[b]} = xf ? 2'b11 : 2'b01;
        default: {ej[b], ek[b]} = xf ? 2'b10 : 2'b00;
      endcase
    end
  endfunction

  // One full transfer on driver idx; entered and left at posedge+1 with the driver idle.
  task automatic xfer(input int idx, input logic [7:0] data);
    logic [7:0] c, ej, ek, eq, emm;
    int emax;
    emax = (idx == 2) ? 3 : 255;
    total++; if (ready_o[idx] !== 1'b1) begin bad++; $display("FAIL ready_idle idx=%0d got=%b want=1", idx, ready_o[idx]); end
    tgt_valid_a[idx] = 1'b1;
    tgt_data_a[idx]  = data;
    c = bank_q[idx];
    exc(idx == 1, c, data, ej, ek);
    eq  = data & ~stuck_a[idx];
    emm = data ^ eq;
    @(posedge clk); #1;
    tgt_valid_a[idx] = 1'b0;
    tgt_data_a[idx]  = 8'($urandom);
    total++; if (j_o[idx] !== ej) begin bad++; $display("FAIL drive_j idx=%0d got=%h want=%h", idx, j_o[idx], ej); end
    total++; if (k_o[idx] !== ek) begin bad++; $display("FAIL drive_k idx=%0d got=%h want=%h", idx, k_o[idx], ek); end
    total++; if ({busy_o[idx], ready_o[idx], done_o[idx]} !== 3'b100) begin bad++; $display("FAIL drive_flags idx=%0d got=%b want=100", idx, {busy_o[idx], ready_o[idx], done_o[idx]}); end
    @(posedge clk); #1;
    total++; if ({j_o[idx], k_o[idx]} !== 16'h0) begin bad++; $display("FAIL check_jk idx=%0d got=%h want=0000", idx, {j_o[idx], k_o[idx]}); end
    total++; if (bank_q[idx] !== eq) begin bad++; $display("FAIL bank_q idx=%0d got=%h want=%h", idx, bank_q[idx], eq); end
    total++; if ({busy_o[idx], ready_o[idx], done_o[idx]} !== 3'b100) begin bad++; $display("FAIL check_flags idx=%0d got=%b want=100", idx, {busy_o[idx], ready_o[idx], done_o[idx]}); end
    @(posedge clk); #1;
    if (emm != 8'h00 && err_model[idx] < emax) err_model[idx]++;
    total++; if ({busy_o[idx], ready_o[idx], done_o[idx]} !== 3'b011) begin bad++; $display("FAIL done_flags idx=%0d got=%b want=011", idx, {busy_o[idx], ready_o[idx], done_o[idx]}); end
    total++; if (mmb_o[idx] !== emm) begin bad++; $display("FAIL mismatch_bits idx=%0d got=%h want=%h", idx, mmb_o[idx], emm); end
    total++; if (mm_o[idx] !== (emm != 8'h00)) begin bad++; $display("FAIL mismatch idx=%0d got=%b want=%b", idx, mm_o[idx], emm != 8'h00); end
    total++; if (errc_o[idx] !== 8'(err_model[idx])) begin bad++; $display("FAIL err_cnt idx=%0d got=%0d want=%0d", idx, errc_o[idx], err_model[idx]); end
    total++; if ({j_o[idx], k_o[idx]} !== 16'h0) begin bad++; $display("FAIL done_jk idx=%0d got=%h want=0000", idx, {j_o[idx], k_o[idx]}); end
    @(posedge clk); #1;
    total++; if (done_o[idx] !== 1'b0) begin bad++; $display("FAIL done_pulse idx=%0d got=%b want=0", idx, done_o[idx]); end
    total++; if (mmb_o[idx] !== emm) begin bad++; $display("FAIL mmb_hold idx=%0d got=%h want=%h", idx, mmb_o[idx], emm); end
    $display("xfer idx=%0d c=%h t=%h j=%h k=%h q=%h mmb=%h err=%0d", idx, c, data, ej, ek, eq, emm, err_model[idx]);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      total++; if ({j_o[i], k_o[i]} !== 16'h0) begin bad++; $display("FAIL %s_jk idx=%0d got=%h want=0000", tag, i, {j_o[i], k_o[i]}); end
      total++; if ({busy_o[i], done_o[i], mm_o[i], ready_o[i]} !== 4'b0000) begin bad++; $display("FAIL %s_flags idx=%0d got=%b want=0000", tag, i, {busy_o[i], done_o[i], mm_o[i], ready_o[i]}); end
      total++; if ({mmb_o[i], errc_o[i]} !== 16'h0) begin bad++; $display("FAIL %s_regs idx=%0d got=%h want=0000", tag, i, {mmb_o[i], errc_o[i]}); end
      err_model[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (ready_o[i] !== 1'b1) begin bad++; $display("FAIL reset_release_ready idx=%0d got=%b want=1", i, ready_o[i]); end
    end
    @(posedge clk); #1;
    $display("reset checked");
  endtask

  task automatic test_xfill0();
    xfer(0, 8'hA5);
    xfer(0, 8'h3C);
  endtask

  task automatic test_xfill1();
    xfer(1, 8'hA5);
    xfer(1, 8'h3C);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      xfer(0, 8'($urandom));
      xfer(1, 8'($urandom));
    end
  endtask

  task automatic test_stuck();
    stuck_a[0] = 8'h01;
    xfer(0, 8'h01);
    stuck_a[0] = 8'h00;
    stuck_a[2] = 8'h01;
    for (int n = 0; n < 5; n++) xfer(2, 8'($urandom) | 8'h01);
    stuck_a[2] = 8'h00;
    xfer(2, 8'h5A);
  endtask

  task automatic test_back_to_back();
    logic [7:0] items [3];
    int sent, dones;
    items[0] = 8'h11; items[1] = 8'h22; items[2] = 8'h33;
    sent = 0; dones = 0;
    tgt_valid_a[0] = 1'b1;
    tgt_data_a[0]  = items[0];
    for (int cyc = 0; cyc <= 9; cyc++) begin
      total++; if (ready_o[0] !== (cyc % 3 == 0)) begin bad++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", cyc, ready_o[0], cyc % 3 == 0); end
      if (done_o[0] === 1'b1) dones++;
      if (cyc == 9) break;
      @(posedge clk); #1;
      if (cyc % 3 == 0) begin
        sent++;
        if (sent < 3) tgt_data_a[0] = items[sent];
        else tgt_valid_a[0] = 1'b0;
      end
    end
    total++; if (dones !== 3) begin bad++; $display("FAIL stream_dones got=%0d want=3", dones); end
    total++; if (bank_q[0] !== 8'h33) begin bad++; $display("FAIL stream_q got=%h want=33", bank_q[0]); end
    total++; if (errc_o[0] !== 8'(err_model[0])) begin bad++; $display("FAIL stream_err got=%0d want=%0d", errc_o[0], err_model[0]); end
    $display("stream sent=%0d dones=%0d q=%h", sent, dones, bank_q[0]);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    tgt_valid_a[0] = 1'b1;
    tgt_data_a[0]  = 8'hC3;
    @(posedge clk); #1;
    tgt_valid_a[0] = 1'b0;
    total++; if (busy_o[0] !== 1'b1) begin bad++; $display("FAIL mid_drive_busy got=%b want=1", busy_o[0]); end
    rst = 1'b1;
    #1;
    total++; if (ready_o[0] !== 1'b0) begin bad++; $display("FAIL mid_ready_in_rst got=%b want=0", ready_o[0]); end
    @(posedge clk); #1;
    check_reset_state("midrst");
    rst = 1'b0;
    #1;
    total++; if (ready_o[0] !== 1'b1) begin bad++; $display("FAIL mid_ready_after got=%b want=1", ready_o[0]); end
    repeat (4) begin
      @(posedge clk); #1;
      if (done_o[0] === 1'b1) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dones); end
    $display("reset mid-transfer checked");
    xfer(0, 8'h96);
  endtask

  initial begin
    tgt_data_a  = '0;
    tgt_valid_a = '0;
    stuck_a     = '0;
    for (int i = 0; i < 3; i++) err_model[i] = 0;
    test_reset();
    test_xfill0();
    test_xfill1();
    test_random();
    test_stuck();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
